reg_load_arbiter: RTL and testbench
===================================

// Module: reg_load_arbiter
// PURPOSE
//  Shares one 8-bit loadable register (async active-low reset, load-enable, hold otherwise)
//  among NREQ write requesters. Round-robin arbitration picks one requester, captures its data,
//  drives the register's din/load for one cycle, then acks the winner. Sits between the
//  requesting blocks and the register.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  data width; must match the register width
// PORTS
//  clock     in   1           system clock, rising edge
//  reset     in   1           reset, asynchronous, active-low
//  req       in   NREQ        req[i]=1: requester i wants to write wdata slice i
//  wdata     in   NREQ*WIDTH  slice i = wdata[i*WIDTH +: WIDTH]
//  ack       out  NREQ        one-hot, one-cycle pulse: requester's write has completed
//  reg_din   out  WIDTH       to register din
//  reg_load  out  1           to register load; 1 for exactly one cycle per grant
//  grant_id  out  clog2(NREQ) index of current/last granted requester
//  busy      out  1           1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, ack=0, reg_load=0, reg_din=0, grant_id=0, busy=0,
//    RR pointer=NREQ-1 (requester 0 highest priority first). A transaction in flight is dropped
//    with no ack; the register is reset by the same net.
//  - FSM IDLE -> LOAD -> ACK -> IDLE, all outputs registered.
//    IDLE: if |req, pick winner = first i with req[i]=1 searching ptr+1, ptr+2, ... modulo NREQ;
//          latch reg_din<=wdata[winner], grant_id<=winner, ptr<=winner, reg_load<=1; go LOAD.
//          If req==0: stay IDLE, outputs hold (reg_load=0, ack=0).
//    LOAD: reg_load=1 this cycle (register captures reg_din at the edge ending LOAD);
//          set ack[grant_id]<=1, reg_load<=0; go ACK.
//    ACK:  ack[grant_id]=1 this cycle; clear ack; go IDLE.
//  - Latency: req seen in IDLE cycle t -> reg_load=1 in t+1 -> register dout=new data in t+2,
//    ack=1 in t+2 -> IDLE in t+3. Max throughput: one write per 3 cycles.
//  - Handshake: requester holds req and wdata stable until it samples ack=1, and must drop req
//    at that same edge (req is 0 in the following IDLE cycle), else a new write is granted.
//  - req/wdata are only sampled in IDLE; changes during LOAD/ACK are ignored. Once granted,
//    the write completes and acks even if req drops.
//  - Simultaneous requests: strict rotation; with all NREQ asserted continuously the grant
//    order is 0,1,2,...,NREQ-1,0 (pointer wraps from NREQ-1 to 0).
//  - A lone requester is re-granted back-to-back (pointer only reorders contenders).
//  - reg_din holds last written value between grants; reg_load never 1 outside LOAD.
// STRUCTURE
//  - Package reg_arb_pkg: typedef enum {IDLE, LOAD, ACK} arb_state_t; default WIDTH/NREQ
//    constants; clog2 helper for grant_id width.
//  - Sub-module rr_pick (combinational): inputs req, ptr; outputs valid, winner index.
//    Arbiter FSM, data mux and output registers stay in reg_load_arbiter.
// TESTING (bench instantiates the 8-bit register driven by reg_din/reg_load)
//  1 reset=0 mid-LOAD with req=4'b0001 -> outputs 0 immediately, no ack, dout=0, then IDLE.
//  2 req=4'b0100, wdata[2]=8'hA5 at IDLE -> reg_load pulse 1 cycle later, dout=8'hA5 and
//    ack=4'b0100 two cycles after request, busy high for exactly 2 cycles.
//  3 req=4'b1111 held (each drops on ack, re-raises next IDLE), data 8'h10..8'h13 -> acks in
//    order 0,1,2,3,0; dout sequence 10,11,12,13,10; one write every 3 cycles.
//  4 after grant to 3, req=4'b1001 -> requester 0 granted next (pointer wrap), then 3.
//  5 wdata[1] changed 8'h3C->8'hFF during LOAD -> dout=8'h3C; req dropped in LOAD -> ack still.
//  6 req=0 for 20 cycles -> reg_load=0, ack=0, dout holds last value, busy=0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the round-robin register-load arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    // grant_id is kept at least one bit wide, even when NREQ is 2
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NREQ.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = id_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  winner
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // ptr itself is searched last, so the previous winner has the lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that shares one loadable register among NREQ write requesters.
//   state | meaning
//   IDLE  | waiting for any req; samples req/wdata and picks a winner
//   LOAD  | reg_load high, register captures reg_din at the closing edge
//   ACK   | one-hot ack pulse to the winner, then back to IDLE
module reg_load_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      reg_din,
    output logic                  reg_load,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    arb_state_t       state, state_nx;
    logic [IDW-1:0]   ptr, ptr_nx;
    logic [IDW-1:0]   grant_id_nx;
    logic [WIDTH-1:0] reg_din_nx;
    logic             reg_load_nx;
    logic [NREQ-1:0]  ack_nx;
    logic             pick_valid;
    logic [IDW-1:0]   pick_id;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        grant_id_nx = grant_id;
        reg_din_nx  = reg_din;
        reg_load_nx = 1'b0;
        ack_nx      = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    reg_din_nx  = wdata[int'(pick_id)*WIDTH +: WIDTH];
                    grant_id_nx = pick_id;
                    ptr_nx      = pick_id;
                    reg_load_nx = 1'b1;
                    state_nx    = LOAD;
                end
            end
            LOAD: begin
                ack_nx[grant_id] = 1'b1;
                state_nx         = ACK;
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr      <= IDW'(NREQ - 1);
            grant_id <= '0;
            reg_din  <= '0;
            reg_load <= 1'b0;
            ack      <= '0;
        end else begin
            ptr      <= ptr_nx;
            grant_id <= grant_id_nx;
            reg_din  <= reg_din_nx;
            reg_load <= reg_load_nx;
            ack      <= ack_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter driving a shared 8-bit loadable register.
module tb_reg_load_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [7:0]  reg_din;
    logic        reg_load;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  dout;

    int tests_run;
    int tests_failed;

    reg_load_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .ack      (ack),
        .reg_din  (reg_din),
        .reg_load (reg_load),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dout <= '0;
        else if (reg_load) dout <= reg_din;
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        wdata[i*8 +: 8] = d;
    endtask

    // Called in an IDLE cycle; performs one complete grant and checks every phase.
    task automatic grant_cycle(input string tag, input logic [3:0] pattern,
                               input int exp_id, input logic [7:0] exp_data);
        logic [3:0] exp_ack;
        exp_ack = 4'b0001 << exp_id;
        req = pattern;
        step();
        chk({tag, " load"},  {31'd0, reg_load}, 32'd1);
        chk({tag, " gid"},   {30'd0, grant_id}, exp_id);
        chk({tag, " din"},   {24'd0, reg_din},  {24'd0, exp_data});
        chk({tag, " busy1"}, {31'd0, busy},     32'd1);
        chk({tag, " ack0"},  {28'd0, ack},      32'd0);
        step();
        chk({tag, " ack"},   {28'd0, ack},      {28'd0, exp_ack});
        chk({tag, " load0"}, {31'd0, reg_load}, 32'd0);
        chk({tag, " dout"},  {24'd0, dout},     {24'd0, exp_data});
        chk({tag, " busy2"}, {31'd0, busy},     32'd1);
        req[exp_id] = 1'b0;
        step();
        chk({tag, " idle"},  {31'd0, busy},     32'd0);
        chk({tag, " ackx"},  {28'd0, ack},      32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        req   = 4'b0000;
        wdata = 32'h0;

        // reset values, then abort a transaction mid-LOAD
        #2;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst load", {31'd0, reg_load}, 32'd0);
        chk("rst ack", {28'd0, ack}, 32'd0);
        chk("rst gid", {30'd0, grant_id}, 32'd0);
        chk("rst din", {24'd0, reg_din}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        set_data(0, 8'h77);
        req = 4'b0001;
        step();
        chk("t1 load", {31'd0, reg_load}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t1 load0", {31'd0, reg_load}, 32'd0);
        chk("t1 busy0", {31'd0, busy}, 32'd0);
        chk("t1 din0", {24'd0, reg_din}, 32'd0);
        chk("t1 dout0", {24'd0, dout}, 32'd0);
        req = 4'b0000;
        #3;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1 noack", {28'd0, ack}, 32'd0);
            chk("t1 idle", {31'd0, busy}, 32'd0);
        end

        // rotation with all four requesting; each re-raises on the next IDLE cycle
        for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
        grant_cycle("t3 g0", 4'b1111, 0, 8'h10);
        grant_cycle("t3 g1", 4'b1111, 1, 8'h11);
        grant_cycle("t3 g2", 4'b1111, 2, 8'h12);
        grant_cycle("t3 g3", 4'b1111, 3, 8'h13);
        grant_cycle("t3 g0b", 4'b1111, 0, 8'h10);

        // pointer wrap from 3 to 0, then lone requester 3 re-granted
        req = 4'b0000;
        step();
        grant_cycle("t4 g3", 4'b1000, 3, 8'h13);
        grant_cycle("t4 g0", 4'b1001, 0, 8'h10);
        grant_cycle("t4 g3b", req, 3, 8'h13);
        grant_cycle("t4 g3c", 4'b1000, 3, 8'h13);

        // single request on slot 2
        set_data(2, 8'hA5);
        grant_cycle("t2", 4'b0100, 2, 8'hA5);

        // data and req changes during LOAD are ignored
        set_data(1, 8'h3C);
        req = 4'b0010;
        step();
        chk("t5 load", {31'd0, reg_load}, 32'd1);
        set_data(1, 8'hFF);
        req = 4'b0000;
        step();
        chk("t5 ack", {28'd0, ack}, 32'h2);
        chk("t5 dout", {24'd0, dout}, 32'h3C);
        step();
        chk("t5 idle", {31'd0, busy}, 32'd0);

        // quiet period: everything holds
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t6 load", {31'd0, reg_load}, 32'd0);
            chk("t6 ack", {28'd0, ack}, 32'd0);
            chk("t6 busy", {31'd0, busy}, 32'd0);
            chk("t6 dout", {24'd0, dout}, 32'h3C);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
